data_mem_responder: RTL and testbench

//   Responder side of the pipeline's M-stage data-memory handshake: accepts one request
//   (read or byte-enabled write), inserts programmable wait states, then pulses

---
 rtl/data_mem_responder.sv | 139 +++++++++++++
 tb/tb_data_mem_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - M-stage data-memory responder with wait states and byte-lane writes
module data_mem_responder #(
   parameter int          DEPTH_LOG2  = 12,
   parameter int          WAIT_STATES = 0,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  byte_en,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        data_mem_ack,
   output logic        busy,
   output logic        addr_err
);
   localparam int         DEPTH     = 1 << DEPTH_LOG2;
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   state_t                state_next;
   logic [3:0]            wait_cnt;
   logic [3:0]            wait_cnt_next;

   logic [31:0]           mem [DEPTH];

   // Request fields captured at the sample edge; held for the whole transaction
   logic                  lat_we;
   logic                  lat_in_range;
   logic [DEPTH_LOG2-1:0] lat_index;
   logic [3:0]            lat_be;
   logic [31:0]           lat_wdata;

   // Address decode relative to the RAM window; byte offset bits are don't-care
   logic [31:0]           offset;
   logic                  in_range;
   logic [DEPTH_LOG2-1:0] index;
   logic                  unused_offset_bits;

   assign offset             = addr - BASE_ADDR;
   assign in_range           = (offset[31:DEPTH_LOG2+2] == '0);
   assign index              = offset[DEPTH_LOG2+1:2];
   assign unused_offset_bits = ^offset[1:0];

   // With zero wait states RESP is entered straight from IDLE, before the latch
   // has been loaded, so the live inputs stand in for the latched fields there.
   logic                  cur_we;
   logic                  cur_in_range;
   logic [DEPTH_LOG2-1:0] cur_index;
   logic [3:0]            cur_be;
   logic [31:0]           cur_wdata;
   logic                  enter_resp;

   assign cur_we       = (state == IDLE) ? we         : lat_we;
   assign cur_in_range = (state == IDLE) ? in_range   : lat_in_range;
   assign cur_index    = (state == IDLE) ? index      : lat_index;
   assign cur_be       = (state == IDLE) ? byte_en    : lat_be;
   assign cur_wdata    = (state == IDLE) ? write_data : lat_wdata;
   assign enter_resp   = (state_next == RESP);

   assign busy = (state != IDLE);

   // Next-state and wait-counter logic
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      case (state)
         IDLE: begin
            if (req) begin
               wait_cnt_next = WAIT_LOAD;
               state_next    = (WAIT_STATES > 0) ? WAIT : RESP;
            end
         end
         WAIT: begin
            if (!req) begin
               state_next    = IDLE;
               wait_cnt_next = '0;
            end else begin
               wait_cnt_next = wait_cnt - 4'd1;
               if (wait_cnt == 4'd1) begin
                  state_next = RESP;
               end
            end
         end
         RESP: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, latched request, registered response and sticky error flag
   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         wait_cnt     <= '0;
         read_data    <= '0;
         data_mem_ack <= 1'b0;
         addr_err     <= 1'b0;
         lat_we       <= 1'b0;
         lat_in_range <= 1'b0;
         lat_index    <= '0;
         lat_be       <= '0;
         lat_wdata    <= '0;
      end else begin
         state        <= state_next;
         wait_cnt     <= wait_cnt_next;
         data_mem_ack <= enter_resp;
         read_data    <= (enter_resp && cur_in_range) ? mem[cur_index] : '0;
         if (enter_resp && !cur_in_range) begin
            addr_err <= 1'b1;
         end
         if (state == IDLE && req) begin
            lat_we       <= we;
            lat_in_range <= in_range;
            lat_index    <= index;
            lat_be       <= byte_en;
            lat_wdata    <= write_data;
         end
      end
   end

   // RAM write commit on the edge entering RESP; contents survive reset
   always_ff @(posedge clk) begin
      if (reset && enter_resp && cur_we && cur_in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (cur_be[i]) begin
               mem[cur_index][8*i +: 8] <= cur_wdata[8*i +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder at 0 and 3 wait states
module tb_data_mem_responder;
   localparam int N = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic [N-1:0]  req, we, ack, busy, err;
   logic [31:0]   addr  [N];
   logic [3:0]    be    [N];
   logic [31:0]   wdata [N];
   logic [31:0]   rdata [N];

   data_mem_responder #(.DEPTH_LOG2(12), .WAIT_STATES(0), .BASE_ADDR(32'h0)) dut0 (
      .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .addr(addr[0]),
      .byte_en(be[0]), .write_data(wdata[0]), .read_data(rdata[0]),
      .data_mem_ack(ack[0]), .busy(busy[0]), .addr_err(err[0]));

   data_mem_responder #(.DEPTH_LOG2(12), .WAIT_STATES(3), .BASE_ADDR(32'h0)) dut3 (
      .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .addr(addr[1]),
      .byte_en(be[1]), .write_data(wdata[1]), .read_data(rdata[1]),
      .data_mem_ack(ack[1]), .busy(busy[1]), .addr_err(err[1]));

   typedef struct {
      int          cyc;
      logic [31:0] data;
      bit          chk;
      bit          oor;
   } exp_t;

   exp_t        sbq     [N][$];
   logic [31:0] ref_mem [N][4096];
   bit          err_m   [N];
   int          n_chk  = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   bit          started = 0;
   bit          rst_q   = 0;

   // Cycle counter and registered view of reset
   always @(posedge clk) begin
      cyc     <= cyc + 1;
      started <= 1'b1;
      rst_q   <= !reset;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops an expectation on every ack and checks idle outputs otherwise
   always @(negedge clk) begin
      exp_t e;
      if (started) begin
         for (int k = 0; k < N; k++) begin
            if (rst_q) begin
               err_m[k] = 1'b0;
               check($sformatf("reset ack dut%0d", k), 32'(ack[k]), 32'd0);
               check($sformatf("reset busy dut%0d", k), 32'(busy[k]), 32'd0);
               check($sformatf("reset read_data dut%0d", k), rdata[k], 32'd0);
               check($sformatf("reset addr_err dut%0d", k), 32'(err[k]), 32'd0);
            end else begin
               if (ack[k]) begin
                  if (sbq[k].size() == 0) begin
                     check($sformatf("unexpected ack dut%0d", k), 32'(ack[k]), 32'd0);
                  end else begin
                     e = sbq[k].pop_front();
                     check($sformatf("ack cycle dut%0d", k), 32'(cyc), 32'(e.cyc));
                     if (e.chk) check($sformatf("read_data dut%0d", k), rdata[k], e.data);
                     if (e.oor) err_m[k] = 1'b1;
                  end
               end else begin
                  check($sformatf("idle read_data dut%0d", k), rdata[k], 32'd0);
               end
               check($sformatf("addr_err dut%0d", k), 32'(err[k]), 32'(err_m[k]));
            end
         end
      end
   end

   // One request: drive, predict from the reference RAM, wait for the ack
   task automatic issue(input int k, input bit w, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d, input bit keep);
      exp_t e;
      int   idx;
      bit   inr;
      bit   got;
      @(negedge clk);
      req[k] = 1'b1; we[k] = w; addr[k] = a; be[k] = b; wdata[k] = d;
      @(posedge clk);
      #1;
      inr    = (a < 32'h4000);
      idx    = int'(a[13:2]);
      e.cyc  = cyc + ((k == 1) ? 3 : 0);
      e.oor  = !inr;
      e.chk  = !w;
      e.data = (!w && inr) ? ref_mem[k][idx] : 32'd0;
      if (w && inr) begin
         for (int i = 0; i < 4; i++) begin
            if (b[i]) ref_mem[k][idx][8*i +: 8] = d[8*i +: 8];
         end
      end
      sbq[k].push_back(e);
      got = 1'b0;
      for (int i = 0; i < 40 && !got; i++) begin
         @(negedge clk);
         got = ack[k];
      end
      if (!got) begin
         n_chk++;
         n_fail++;
         $display("FAIL ack timeout dut%0d addr %h: no ack within 40 cycles", k, a);
      end
      if (!keep) req[k] = 1'b0;
   endtask

   // Write abandoned two cycles into the wait states
   task automatic flush_write(input int k, input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      req[k] = 1'b1; we[k] = 1'b1; addr[k] = a; be[k] = 4'hF; wdata[k] = d;
      @(negedge clk);
      @(negedge clk);
      check($sformatf("busy during wait dut%0d", k), 32'(busy[k]), 32'd1);
      req[k] = 1'b0;
      repeat (3) @(negedge clk);
      check($sformatf("busy after flush dut%0d", k), 32'(busy[k]), 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Stimulus
   initial begin
      logic [31:0] a;
      bit          keep;
      reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         req[k] = 1'b1; we[k] = 1'b1; addr[k] = 32'h10; be[k] = 4'hF; wdata[k] = 32'h12345678;
      end
      repeat (3) @(negedge clk);
      req = '0;
      @(negedge clk);
      reset = 1'b1;

      for (int k = 0; k < N; k++) begin
         issue(k, 1'b1, 32'h0, 4'hF, 32'hA5A5_0000, 1'b0);
         issue(k, 1'b1, 32'h4, 4'hF, 32'hA5A5_0004, 1'b0);
         issue(k, 1'b1, 32'h8, 4'hF, 32'hA5A5_0008, 1'b0);
         for (int i = 0; i < 16; i++) issue(k, 1'b1, 32'h100 + 32'(4*i), 4'hF, $urandom, 1'b0);
         issue(k, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0);
         issue(k, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);
         issue(k, 1'b1, 32'h20, 4'hF, 32'h1122_3344, 1'b0);
         issue(k, 1'b1, 32'h20, 4'b0100, 32'hAAAA_AAAA, 1'b0);
         issue(k, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
         issue(k, 1'b1, 32'h20, 4'b0000, 32'h5555_5555, 1'b0);
         issue(k, 1'b0, 32'h20, 4'h0, 32'h0, 1'b0);
      end

      issue(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      flush_write(1, 32'h0, 32'hFFFF_FFFF);
      issue(1, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);

      for (int k = 0; k < N; k++) begin
         issue(k, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
         issue(k, 1'b0, 32'h4, 4'h0, 32'h0, 1'b1);
         issue(k, 1'b0, 32'h8, 4'h0, 32'h0, 1'b0);
      end

      for (int k = 0; k < N; k++) begin
         for (int i = 0; i < 60; i++) begin
            a    = ($urandom_range(0, 9) == 0) ? 32'h4000 + 32'($urandom_range(0, 255))
                                               : 32'h100 + 32'(4*$urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            keep = (i != 59) && ($urandom_range(0, 1) == 1);
            issue(k, 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, keep);
         end
      end

      for (int k = 0; k < N; k++) begin
         issue(k, 1'b1, 32'h4000, 4'hF, 32'hCAFE_F00D, 1'b0);
         issue(k, 1'b0, 32'h4000, 4'h0, 32'h0, 1'b0);
         issue(k, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
      end
      do_reset();
      for (int k = 0; k < N; k++) issue(k, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);

      repeat (8) @(negedge clk);
      for (int k = 0; k < N; k++) check($sformatf("pending acks dut%0d", k), 32'(sbq[k].size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end
endmodule
